frv_rvfi_trace: RTL and testbench



---
 rtl/frv_rvfi_trace.sv | 177 +++++++++++++++++
 tb/tb_frv_rvfi_trace.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frv_rvfi_trace.sv
// RVFI retirement trace generator: buffers execute-side operand records and
// merges each with its writeback result into one registered RVFI record.
module frv_rvfi_trace #(
  parameter int ORDER_W = 64
) (
  input  logic               g_clk,
  input  logic               g_resetn,
  input  logic               ex_valid,
  output logic               ex_ready,
  input  logic [31:0]        ex_insn,
  input  logic [31:0]        ex_pc,
  input  logic [4:0]         ex_rs1_addr,
  input  logic [4:0]         ex_rs2_addr,
  input  logic [4:0]         ex_rs3_addr,
  input  logic [31:0]        ex_rs1_rdata,
  input  logic [31:0]        ex_rs2_rdata,
  input  logic [31:0]        ex_rs3_rdata,
  input  logic               wb_valid,
  input  logic               wb_trap,
  input  logic [4:0]         wb_rd_addr,
  input  logic [31:0]        wb_rd_wdata,
  input  logic [31:0]        wb_rd_wdatahi,
  input  logic               wb_rd_wide,
  input  logic [31:0]        wb_pc_wdata,
  input  logic [31:0]        wb_mem_addr,
  input  logic [31:0]        wb_mem_rdata,
  input  logic [31:0]        wb_mem_wdata,
  input  logic [3:0]         wb_mem_rmask,
  input  logic [3:0]         wb_mem_wmask,
  input  logic               flush,
  output logic               rvfi_valid,
  output logic [ORDER_W-1:0] rvfi_order,
  output logic [31:0]        rvfi_insn,
  output logic [31:0]        rvfi_pc_rdata,
  output logic [31:0]        rvfi_pc_wdata,
  output logic               rvfi_trap,
  output logic               rvfi_halt,
  output logic               rvfi_intr,
  output logic [4:0]         rvfi_rs1_addr,
  output logic [4:0]         rvfi_rs2_addr,
  output logic [4:0]         rvfi_rs3_addr,
  output logic [31:0]        rvfi_rs1_rdata,
  output logic [31:0]        rvfi_rs2_rdata,
  output logic [31:0]        rvfi_rs3_rdata,
  output logic [4:0]         rvfi_rd_addr,
  output logic [31:0]        rvfi_rd_wdata,
  output logic [31:0]        rvfi_rd_wdatahi,
  output logic               rvfi_rd_wide,
  output logic [31:0]        rvfi_mem_addr,
  output logic [31:0]        rvfi_mem_rdata,
  output logic [31:0]        rvfi_mem_wdata,
  output logic [3:0]         rvfi_mem_rmask,
  output logic [3:0]         rvfi_mem_wmask,
  output logic               trace_err
);

  logic [1:0]         count;
  logic               wr_ptr;
  logic               rd_ptr;
  logic [ORDER_W-1:0] order_cnt;
  logic               push;
  logic               pop;
  logic               rd_keep;
  logic               data_keep;
  logic               hi_keep;

  logic [31:0] buf_insn     [2];
  logic [31:0] buf_pc       [2];
  logic [4:0]  buf_rs1_addr [2];
  logic [4:0]  buf_rs2_addr [2];
  logic [4:0]  buf_rs3_addr [2];
  logic [31:0] buf_rs1_rdata[2];
  logic [31:0] buf_rs2_rdata[2];
  logic [31:0] buf_rs3_rdata[2];

  assign ex_ready  = (count != 2'd2);
  assign push      = ex_valid && ex_ready && !flush;
  assign pop       = wb_valid && (count != 2'd0);
  assign rvfi_halt = 1'b0;
  assign rvfi_intr = 1'b0;

  // A trap suppresses all destination effects; x0 never carries write data.
  assign rd_keep   = !wb_trap;
  assign data_keep = rd_keep && (wb_rd_addr != 5'd0);
  assign hi_keep   = data_keep && wb_rd_wide;

  always_ff @(posedge g_clk) begin
    if (push) begin
      buf_insn[wr_ptr]      <= ex_insn;
      buf_pc[wr_ptr]        <= ex_pc;
      buf_rs1_addr[wr_ptr]  <= ex_rs1_addr;
      buf_rs2_addr[wr_ptr]  <= ex_rs2_addr;
      buf_rs3_addr[wr_ptr]  <= ex_rs3_addr;
      buf_rs1_rdata[wr_ptr] <= ex_rs1_rdata;
      buf_rs2_rdata[wr_ptr] <= ex_rs2_rdata;
      buf_rs3_rdata[wr_ptr] <= ex_rs3_rdata;
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      trace_err <= 1'b0;
    end else begin
      if (flush) begin
        count  <= 2'd0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
      if (wb_valid && (count == 2'd0)) trace_err <= 1'b1;
    end
  end

  // The oldest entry retires even in a flush cycle; the flush only drops the rest.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      rvfi_valid      <= 1'b0;
      rvfi_order      <= '0;
      order_cnt       <= '0;
      rvfi_insn       <= '0;
      rvfi_pc_rdata   <= '0;
      rvfi_pc_wdata   <= '0;
      rvfi_trap       <= 1'b0;
      rvfi_rs1_addr   <= '0;
      rvfi_rs2_addr   <= '0;
      rvfi_rs3_addr   <= '0;
      rvfi_rs1_rdata  <= '0;
      rvfi_rs2_rdata  <= '0;
      rvfi_rs3_rdata  <= '0;
      rvfi_rd_addr    <= '0;
      rvfi_rd_wdata   <= '0;
      rvfi_rd_wdatahi <= '0;
      rvfi_rd_wide    <= 1'b0;
      rvfi_mem_addr   <= '0;
      rvfi_mem_rdata  <= '0;
      rvfi_mem_wdata  <= '0;
      rvfi_mem_rmask  <= '0;
      rvfi_mem_wmask  <= '0;
    end else begin
      rvfi_valid <= pop;
      if (pop) begin
        rvfi_order      <= order_cnt;
        order_cnt       <= order_cnt + ORDER_W'(1);
        rvfi_insn       <= buf_insn[rd_ptr];
        rvfi_pc_rdata   <= buf_pc[rd_ptr];
        rvfi_pc_wdata   <= wb_pc_wdata;
        rvfi_trap       <= wb_trap;
        rvfi_rs1_addr   <= buf_rs1_addr[rd_ptr];
        rvfi_rs2_addr   <= buf_rs2_addr[rd_ptr];
        rvfi_rs3_addr   <= buf_rs3_addr[rd_ptr];
        rvfi_rs1_rdata  <= buf_rs1_rdata[rd_ptr];
        rvfi_rs2_rdata  <= buf_rs2_rdata[rd_ptr];
        rvfi_rs3_rdata  <= buf_rs3_rdata[rd_ptr];
        rvfi_rd_addr    <= rd_keep   ? wb_rd_addr    : 5'd0;
        rvfi_rd_wdata   <= data_keep ? wb_rd_wdata   : 32'd0;
        rvfi_rd_wdatahi <= hi_keep   ? wb_rd_wdatahi : 32'd0;
        rvfi_rd_wide    <= rd_keep && wb_rd_wide;
        rvfi_mem_addr   <= wb_mem_addr;
        rvfi_mem_rdata  <= wb_mem_rdata;
        rvfi_mem_wdata  <= wb_mem_wdata;
        rvfi_mem_rmask  <= rd_keep ? wb_mem_rmask : 4'd0;
        rvfi_mem_wmask  <= rd_keep ? wb_mem_wmask : 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_frv_rvfi_trace.sv
// Scoreboard bench for frv_rvfi_trace: stimulus pushes expected retirement
// records into a queue, a negedge monitor pops and compares each rvfi record.
module tb_frv_rvfi_trace;

  typedef struct {
    logic [31:0] insn, pc;
    logic [4:0]  rs1a, rs2a, rs3a;
    logic [31:0] rs1d, rs2d, rs3d;
  } ex_rec_t;

  typedef struct {
    logic        trap;
    logic [4:0]  rd;
    logic [31:0] wdata, wdatahi;
    logic        wide;
    logic [31:0] pcw, maddr, mrdata, mwdata;
    logic [3:0]  rmask, wmask;
  } wb_rec_t;

  typedef struct {
    ex_rec_t    ex;
    wb_rec_t    wb;
    logic [3:0] order;
    int         due;
  } exp_t;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        ex_valid = 1'b0, ex_ready;
  logic [31:0] ex_insn = '0, ex_pc = '0;
  logic [4:0]  ex_rs1_addr = '0, ex_rs2_addr = '0, ex_rs3_addr = '0;
  logic [31:0] ex_rs1_rdata = '0, ex_rs2_rdata = '0, ex_rs3_rdata = '0;
  logic        wb_valid = 1'b0, wb_trap = 1'b0, wb_rd_wide = 1'b0;
  logic [4:0]  wb_rd_addr = '0;
  logic [31:0] wb_rd_wdata = '0, wb_rd_wdatahi = '0, wb_pc_wdata = '0;
  logic [31:0] wb_mem_addr = '0, wb_mem_rdata = '0, wb_mem_wdata = '0;
  logic [3:0]  wb_mem_rmask = '0, wb_mem_wmask = '0;
  logic        flush = 1'b0;
  logic        rvfi_valid, rvfi_trap, rvfi_halt, rvfi_intr, rvfi_rd_wide, trace_err;
  logic [3:0]  rvfi_order, rvfi_mem_rmask, rvfi_mem_wmask;
  logic [31:0] rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata;
  logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs3_addr, rvfi_rd_addr;
  logic [31:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rs3_rdata;
  logic [31:0] rvfi_rd_wdata, rvfi_rd_wdatahi;
  logic [31:0] rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;

  int       total = 0;
  int       bad = 0;
  int       cyc = 0;
  exp_t     sb[$];
  ex_rec_t  model_q[$];
  logic [3:0] model_order = '0;
  logic     model_err = 1'b0;

  frv_rvfi_trace #(.ORDER_W(4)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_insn(ex_insn), .ex_pc(ex_pc),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rs3_addr(ex_rs3_addr),
    .ex_rs1_rdata(ex_rs1_rdata), .ex_rs2_rdata(ex_rs2_rdata), .ex_rs3_rdata(ex_rs3_rdata),
    .wb_valid(wb_valid), .wb_trap(wb_trap), .wb_rd_addr(wb_rd_addr),
    .wb_rd_wdata(wb_rd_wdata), .wb_rd_wdatahi(wb_rd_wdatahi), .wb_rd_wide(wb_rd_wide),
    .wb_pc_wdata(wb_pc_wdata), .wb_mem_addr(wb_mem_addr), .wb_mem_rdata(wb_mem_rdata),
    .wb_mem_wdata(wb_mem_wdata), .wb_mem_rmask(wb_mem_rmask), .wb_mem_wmask(wb_mem_wmask),
    .flush(flush),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata), .rvfi_trap(rvfi_trap),
    .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
    .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rs3_addr(rvfi_rs3_addr),
    .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata), .rvfi_rs3_rdata(rvfi_rs3_rdata),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_rd_wdatahi(rvfi_rd_wdatahi),
    .rvfi_rd_wide(rvfi_rd_wide), .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rdata(rvfi_mem_rdata),
    .rvfi_mem_wdata(rvfi_mem_wdata), .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
    .trace_err(trace_err)
  );

  always #5 g_clk = ~g_clk;
  always @(posedge g_clk) cyc = cyc + 1;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] req);
    total = total + 1;
    if (act !== req) begin
      bad = bad + 1;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic ex_rec_t mk_ex(input logic [31:0] insn, input logic [31:0] pc,
                                    input logic [4:0] r1a, input logic [31:0] r1d,
                                    input logic [4:0] r2a, input logic [31:0] r2d);
    ex_rec_t e;
    e.insn = insn; e.pc = pc;
    e.rs1a = r1a; e.rs1d = r1d; e.rs2a = r2a; e.rs2d = r2d;
    e.rs3a = r1a ^ r2a; e.rs3d = r1d + r2d;
    return e;
  endfunction

  function automatic wb_rec_t mk_wb(input logic trap, input logic [4:0] rd,
                                    input logic [31:0] wdata, input logic [31:0] wdatahi,
                                    input logic wide, input logic [31:0] pcw,
                                    input logic [3:0] rmask, input logic [3:0] wmask);
    wb_rec_t w;
    w.trap = trap; w.rd = rd; w.wdata = wdata; w.wdatahi = wdatahi; w.wide = wide;
    w.pcw = pcw; w.rmask = rmask; w.wmask = wmask;
    w.maddr = pcw ^ 32'h1000_0000; w.mrdata = ~wdata; w.mwdata = wdata ^ 32'h5A5A_5A5A;
    return w;
  endfunction

  // One clock of stimulus; the model decides what the DUT should retire.
  task automatic applyStimulus(input logic dex, input ex_rec_t e, input logic dwb,
                               input wb_rec_t w, input logic dfl);
    exp_t x;
    logic ready;
    ready = (model_q.size() != 2);
    checkOutput("ex_ready", ex_ready, ready);
    ex_valid = dex; ex_insn = e.insn; ex_pc = e.pc;
    ex_rs1_addr = e.rs1a; ex_rs2_addr = e.rs2a; ex_rs3_addr = e.rs3a;
    ex_rs1_rdata = e.rs1d; ex_rs2_rdata = e.rs2d; ex_rs3_rdata = e.rs3d;
    wb_valid = dwb; wb_trap = w.trap; wb_rd_addr = w.rd; wb_rd_wdata = w.wdata;
    wb_rd_wdatahi = w.wdatahi; wb_rd_wide = w.wide; wb_pc_wdata = w.pcw;
    wb_mem_addr = w.maddr; wb_mem_rdata = w.mrdata; wb_mem_wdata = w.mwdata;
    wb_mem_rmask = w.rmask; wb_mem_wmask = w.wmask;
    flush = dfl;
    if (dwb) begin
      if (model_q.size() != 0) begin
        x.ex = model_q.pop_front();
        x.wb = w;
        if (w.trap) begin
          x.wb.rd = '0; x.wb.wdata = '0; x.wb.wdatahi = '0; x.wb.wide = 1'b0;
          x.wb.rmask = '0; x.wb.wmask = '0;
        end
        if (w.rd == 5'd0) begin
          x.wb.wdata = '0; x.wb.wdatahi = '0;
        end
        if (!w.wide) x.wb.wdatahi = '0;
        x.order = model_order;
        model_order = model_order + 4'd1;
        x.due = cyc + 1;
        sb.push_back(x);
      end else begin
        model_err = 1'b1;
      end
    end
    if (dfl) model_q.delete();
    else if (dex && ready) model_q.push_back(e);
    @(posedge g_clk);
    #1;
    ex_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0;
  endtask

  // Monitor: every rvfi_valid must match the oldest expectation on its due cycle.
  always @(negedge g_clk) begin
    if (g_resetn) begin
      if (rvfi_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_valid", 1, 0);
        end else begin
          exp_t x;
          x = sb.pop_front();
          checkOutput("latency", cyc, x.due);
          checkOutput("order", rvfi_order, x.order);
          checkOutput("ex_side",
                      {rvfi_insn, rvfi_pc_rdata, rvfi_rs1_addr, rvfi_rs1_rdata, rvfi_rs2_addr,
                       rvfi_rs2_rdata, rvfi_rs3_addr, rvfi_rs3_rdata},
                      {x.ex.insn, x.ex.pc, x.ex.rs1a, x.ex.rs1d, x.ex.rs2a, x.ex.rs2d,
                       x.ex.rs3a, x.ex.rs3d});
          checkOutput("rd_side", {rvfi_trap, rvfi_rd_addr, rvfi_rd_wdata, rvfi_rd_wdatahi, rvfi_rd_wide},
                      {x.wb.trap, x.wb.rd, x.wb.wdata, x.wb.wdatahi, x.wb.wide});
          checkOutput("mem_side",
                      {rvfi_pc_wdata, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata,
                       rvfi_mem_rmask, rvfi_mem_wmask},
                      {x.wb.pcw, x.wb.maddr, x.wb.mrdata, x.wb.mwdata, x.wb.rmask, x.wb.wmask});
          checkOutput("halt_intr", {rvfi_halt, rvfi_intr}, 2'b00);
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        checkOutput("missing_valid", 0, 1);
        void'(sb.pop_front());
      end
    end
  end

  ex_rec_t e0;
  wb_rec_t w0;

  task automatic idle();
    applyStimulus(1'b0, e0, 1'b0, w0, 1'b0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_valid"}, rvfi_valid, 0);
    checkOutput({tag, "_payload"}, {rvfi_order, rvfi_insn, rvfi_pc_rdata, rvfi_rd_wdata}, 0);
    checkOutput({tag, "_ready"}, ex_ready, 1);
    checkOutput({tag, "_err"}, trace_err, 0);
  endtask

  task automatic resetDut(input logic with_wb);
    g_resetn = 1'b0;
    wb_valid = with_wb;
    @(posedge g_clk);
    #1;
    g_resetn = 1'b1;
    wb_valid = 1'b0;
    model_q.delete();
    model_order = '0;
    model_err = 1'b0;
  endtask

  initial begin
    e0 = mk_ex('0, '0, '0, '0, '0, '0);
    w0 = mk_wb(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    resetDut(1'b0);
    resetDut(1'b0);
    checkResetState("reset");

    $display("[TB] single instruction");
    applyStimulus(1'b1, mk_ex(32'h0C0F2033, 32'h80, 5'd1, 32'h11, 5'd2, 32'h22), 1'b0, w0, 1'b0);
    applyStimulus(1'b0, e0, 1'b1, mk_wb(1'b0, 5'd5, 32'hDEADBEEF, 32'h0, 1'b0, 32'h84, 4'h0, 4'h0), 1'b0);
    idle(); idle();

    $display("[TB] fill and backpressure");
    applyStimulus(1'b1, mk_ex(32'h00100093, 32'h84, 5'd3, 32'h33, 5'd4, 32'h44), 1'b0, w0, 1'b0);
    applyStimulus(1'b1, mk_ex(32'h00200113, 32'h88, 5'd6, 32'h66, 5'd7, 32'h77), 1'b0, w0, 1'b0);
    checkOutput("full_ready", ex_ready, 0);
    applyStimulus(1'b1, mk_ex(32'hFFFFFFFF, 32'h8C, 5'd9, 32'h99, 5'd10, 32'hAA), 1'b1,
                  mk_wb(1'b0, 5'd8, 32'h1111, 32'h0, 1'b0, 32'h88, 4'h0, 4'h0), 1'b0);
    applyStimulus(1'b0, e0, 1'b1, mk_wb(1'b0, 5'd9, 32'h2222, 32'h3333, 1'b1, 32'h8C, 4'hF, 4'h0), 1'b0);
    idle(); idle();
    checkOutput("drained_err", trace_err, 0);

    $display("[TB] rd=x0, trap, wide");
    applyStimulus(1'b1, mk_ex(32'h00000033, 32'h90, 5'd1, 32'h5, 5'd2, 32'h6), 1'b0, w0, 1'b0);
    applyStimulus(1'b0, e0, 1'b1, mk_wb(1'b0, 5'd0, 32'h1234, 32'h5678, 1'b1, 32'h94, 4'h3, 4'h0), 1'b0);
    applyStimulus(1'b1, mk_ex(32'h00E7A023, 32'h94, 5'd15, 32'h100, 5'd14, 32'hAB), 1'b0, w0, 1'b0);
    applyStimulus(1'b0, e0, 1'b1, mk_wb(1'b1, 5'd7, 32'hCAFEF00D, 32'h9, 1'b1, 32'h200, 4'hF, 4'hF), 1'b0);
    applyStimulus(1'b1, mk_ex(32'h02B50533, 32'h98, 5'd10, 32'h7, 5'd11, 32'h8), 1'b0, w0, 1'b0);
    applyStimulus(1'b0, e0, 1'b1, mk_wb(1'b0, 5'd10, 32'h38, 32'hFEED, 1'b0, 32'h9C, 4'h0, 4'h0), 1'b0);
    applyStimulus(1'b1, mk_ex(32'h02B50534, 32'h9C, 5'd12, 32'h1, 5'd13, 32'h2), 1'b0, w0, 1'b0);
    applyStimulus(1'b0, e0, 1'b1, mk_wb(1'b0, 5'd11, 32'h40, 32'hBEEF, 1'b1, 32'hA0, 4'h0, 4'h1), 1'b0);
    idle(); idle();

    $display("[TB] flush with retire");
    applyStimulus(1'b1, mk_ex(32'h11111111, 32'hA0, 5'd1, 32'h1, 5'd2, 32'h2), 1'b0, w0, 1'b0);
    applyStimulus(1'b1, mk_ex(32'h22222222, 32'hA4, 5'd3, 32'h3, 5'd4, 32'h4), 1'b0, w0, 1'b0);
    applyStimulus(1'b1, mk_ex(32'h33333333, 32'hA8, 5'd5, 32'h5, 5'd6, 32'h6), 1'b1,
                  mk_wb(1'b0, 5'd12, 32'hAAAA, 32'h0, 1'b0, 32'hA4, 4'h0, 4'h0), 1'b1);
    idle(); idle();
    checkOutput("flush_err_clear", trace_err, 0);
    applyStimulus(1'b0, e0, 1'b1, mk_wb(1'b0, 5'd1, 32'h1, 32'h0, 1'b0, 32'h0, 4'h0, 4'h0), 1'b0);
    idle(); idle();
    checkOutput("flush_err_set", trace_err, model_err);
    checkOutput("flush_err_one", trace_err, 1);
    idle();
    checkOutput("err_sticky", trace_err, 1);

    $display("[TB] order wrap");
    resetDut(1'b0);
    checkResetState("wrap_reset");
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, mk_ex(32'h1000 + i, 32'h400 + 4 * i, 5'(i), 32'(i * 3), 5'(i + 1), 32'(i * 5)),
                    1'b0, w0, 1'b0);
      applyStimulus(1'b0, e0, 1'b1, mk_wb(1'b0, 5'(i + 1), 32'(i * 7), 32'h0, 1'b0, 32'h404 + 4 * i,
                    4'h0, 4'h0), 1'b0);
    end
    idle(); idle();

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, mk_ex(32'h55555555, 32'hC0, 5'd1, 32'h1, 5'd2, 32'h2), 1'b0, w0, 1'b0);
    applyStimulus(1'b1, mk_ex(32'h66666666, 32'hC4, 5'd3, 32'h3, 5'd4, 32'h4), 1'b0, w0, 1'b0);
    resetDut(1'b1);
    checkResetState("mid_reset");
    idle();
    checkOutput("mid_reset_quiet", rvfi_valid, 0);
    applyStimulus(1'b1, mk_ex(32'h77777777, 32'hC8, 5'd5, 32'h5, 5'd6, 32'h6), 1'b0, w0, 1'b0);
    applyStimulus(1'b0, e0, 1'b1, mk_wb(1'b0, 5'd3, 32'h9999, 32'h0, 1'b0, 32'hCC, 4'h0, 4'h0), 1'b0);
    idle(); idle(); idle();

    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
